// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// mem_ctrl : serialises word loads/stores/fetches onto an 8-bit sync RAM port
// Rev 1.0
// ============================================================================
module mem_ctrl #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mm_mct_e,
   input  logic              mm_mct_wr,
   input  logic [1:0]        mm_mct_cu,
   input  logic [31:0]       mm_mct_a,
   input  logic [31:0]       mm_mct_n_i,
   output logic [31:0]       mm_mct_n_o,
   output logic              mm_mct_ok,
   input  logic              if_mct_e,
   input  logic [31:0]       if_mct_a,
   output logic [31:0]       if_mct_n_o,
   output logic              if_mct_ok,
   input  logic [7:0]        mem_din,
   output logic [7:0]        mem_dout,
   output logic [ADDR_W-1:0] mem_a,
   output logic              mem_wr
);
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]  state_q, state_d;
   logic        src_q, src_d;       // 1 = fetch port owns the transaction
   logic        wr_q, wr_d;
   logic [31:0] base_q, base_d;
   logic [2:0]  nbytes_q, nbytes_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [31:0] sdata_q, sdata_d;
   logic [31:0] mm_n_q, mm_n_d;
   logic [31:0] if_n_q, if_n_d;

   logic        w_busy;
   logic [31:0] w_addr;
   logic [1:0]  w_rd_idx;
   logic        w_last;

   assign w_busy   = (state_q == ST_BUSY);
   assign w_addr   = base_q + {29'd0, cnt_q};
   // RAM data lags the address by one cycle, so cnt addresses byte cnt-1 on reads
   assign w_rd_idx = cnt_q[1:0] - 2'd1;
   assign w_last   = wr_q ? (cnt_q == (nbytes_q - 3'd1)) : (cnt_q == nbytes_q);

   always_comb begin
      state_d  = state_q;
      src_d    = src_q;
      wr_d     = wr_q;
      base_d   = base_q;
      nbytes_d = nbytes_q;
      cnt_d    = cnt_q;
      sdata_d  = sdata_q;
      mm_n_d   = mm_n_q;
      if_n_d   = if_n_q;
      case (state_q)
         ST_IDLE: begin
            if (mm_mct_e) begin
               src_d    = 1'b0;
               wr_d     = mm_mct_wr;
               base_d   = mm_mct_a;
               nbytes_d = {1'b0, mm_mct_cu} + 3'd1;
               sdata_d  = mm_mct_n_i;
               mm_n_d   = 32'd0;
               cnt_d    = 3'd0;
               state_d  = ST_BUSY;
            end else if (if_mct_e) begin
               src_d    = 1'b1;
               wr_d     = 1'b0;
               base_d   = if_mct_a;
               nbytes_d = 3'd4;
               sdata_d  = 32'd0;
               if_n_d   = 32'd0;
               cnt_d    = 3'd0;
               state_d  = ST_BUSY;
            end
         end
         ST_BUSY: begin
            cnt_d = cnt_q + 3'd1;
            if (!wr_q && (cnt_q != 3'd0)) begin
               if (src_q) begin
                  if_n_d[{w_rd_idx, 3'b000} +: 8] = mem_din;
               end else begin
                  mm_n_d[{w_rd_idx, 3'b000} +: 8] = mem_din;
               end
            end
            if (w_last) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         src_q    <= 1'b0;
         wr_q     <= 1'b0;
         base_q   <= 32'd0;
         nbytes_q <= 3'd0;
         cnt_q    <= 3'd0;
         sdata_q  <= 32'd0;
         mm_n_q   <= 32'd0;
         if_n_q   <= 32'd0;
      end else begin
         state_q  <= state_d;
         src_q    <= src_d;
         wr_q     <= wr_d;
         base_q   <= base_d;
         nbytes_q <= nbytes_d;
         cnt_q    <= cnt_d;
         sdata_q  <= sdata_d;
         mm_n_q   <= mm_n_d;
         if_n_q   <= if_n_d;
      end
   end

   assign mm_mct_n_o = mm_n_q;
   assign if_mct_n_o = if_n_q;
   assign mm_mct_ok  = (state_q == ST_DONE) && !src_q;
   assign if_mct_ok  = (state_q == ST_DONE) &&  src_q;
   assign mem_a      = w_busy ? w_addr[ADDR_W-1:0] : '0;
   assign mem_wr     = w_busy && wr_q && (cnt_q < nbytes_q);
   assign mem_dout   = w_busy ? sdata_q[{cnt_q[1:0], 3'b000} +: 8] : 8'd0;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mem_ctrl : directed bench with a transaction-level reference model
// Rev 1.0
// ============================================================================
module tb_mem_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mm_mct_e = 1'b0;
   logic        mm_mct_wr = 1'b0;
   logic [1:0]  mm_mct_cu = 2'd0;
   logic [31:0] mm_mct_a = 32'd0;
   logic [31:0] mm_mct_n_i = 32'd0;
   logic [31:0] mm_mct_n_o;
   logic        mm_mct_ok;
   logic        if_mct_e = 1'b0;
   logic [31:0] if_mct_a = 32'd0;
   logic [31:0] if_mct_n_o;
   logic        if_mct_ok;
   logic [7:0]  mem_din = 8'd0;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;

   mem_ctrl #(.ADDR_W(32)) dut (
      .clk(clk), .rst(rst),
      .mm_mct_e(mm_mct_e), .mm_mct_wr(mm_mct_wr), .mm_mct_cu(mm_mct_cu),
      .mm_mct_a(mm_mct_a), .mm_mct_n_i(mm_mct_n_i), .mm_mct_n_o(mm_mct_n_o),
      .mm_mct_ok(mm_mct_ok),
      .if_mct_e(if_mct_e), .if_mct_a(if_mct_a), .if_mct_n_o(if_mct_n_o),
      .if_mct_ok(if_mct_ok),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Physical RAM seen by the DUT and an independent reference copy for the model
   logic [7:0] ram [logic [31:0]];
   logic [7:0] ref_mem [logic [31:0]];

   task automatic preload(input logic [31:0] a, input logic [7:0] v);
      ram[a] = v;
      ref_mem[a] = v;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
         if (mem_wr) ram[mem_a] = mem_dout;
      end
   end

   // Reference model: phase 0 idle, 1 active (k cycles since accept), 2 ok cycle
   int          m_phase = 0;
   int          m_k = 0;
   int          m_L = 0;
   int          m_nb = 0;
   logic        m_src = 1'b0;
   logic        m_wr = 1'b0;
   logic [31:0] m_base = 32'd0;
   logic [31:0] m_sdata = 32'd0;
   logic [31:0] m_res = 32'd0;
   logic [31:0] exp_mm_n = 32'd0;
   logic [31:0] exp_if_n = 32'd0;

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_phase  = 0;
            exp_mm_n = 32'd0;
            exp_if_n = 32'd0;
         end else begin
            case (m_phase)
               0: begin
                  if (mm_mct_e || if_mct_e) begin
                     m_src   = !mm_mct_e;
                     m_wr    = mm_mct_e ? mm_mct_wr : 1'b0;
                     m_base  = mm_mct_e ? mm_mct_a : if_mct_a;
                     m_nb    = mm_mct_e ? int'(mm_mct_cu) + 1 : 4;
                     m_sdata = mm_mct_e ? mm_mct_n_i : 32'd0;
                     m_L     = m_wr ? m_nb : m_nb + 1;
                     m_k     = 0;
                     m_phase = 1;
                     m_res   = 32'd0;
                     if (m_src) exp_if_n = 32'd0;
                     else exp_mm_n = 32'd0;
                     for (int i = 0; i < m_nb; i++) begin
                        if (m_wr) ref_mem[m_base + 32'(i)] = m_sdata[8*i +: 8];
                        else if (ref_mem.exists(m_base + 32'(i)))
                           m_res[8*i +: 8] = ref_mem[m_base + 32'(i)];
                     end
                  end
               end
               1: begin
                  m_k++;
                  if (m_k == m_L) begin
                     m_phase = 2;
                     if (m_src) exp_if_n = m_res;
                     else exp_mm_n = m_res;
                  end
               end
               default: m_phase = 0;
            endcase
         end
      end
   end

   task automatic compare_outputs();
      logic exp_wr;
      if (m_phase == 1) begin
         exp_wr = m_wr && (m_k < m_nb);
         chk("mem_a", mem_a, m_base + 32'(m_k));
         chk("mem_wr", 32'(mem_wr), 32'(exp_wr));
         if (exp_wr) chk("mem_dout", 32'(mem_dout), 32'(m_sdata[8*m_k +: 8]));
         chk("mm_ok_busy", 32'(mm_mct_ok), 32'd0);
         chk("if_ok_busy", 32'(if_mct_ok), 32'd0);
         if (m_src || m_wr) chk("mm_n_o_busy", mm_mct_n_o, exp_mm_n);
         if (!m_src) chk("if_n_o_busy", if_mct_n_o, exp_if_n);
      end else begin
         chk("mem_a_idle", mem_a, 32'd0);
         chk("mem_wr_idle", 32'(mem_wr), 32'd0);
         chk("mem_dout_idle", 32'(mem_dout), 32'd0);
         chk("mm_ok", 32'(mm_mct_ok), 32'((m_phase == 2) && !m_src));
         chk("if_ok", 32'(if_mct_ok), 32'((m_phase == 2) && m_src));
         chk("mm_n_o", mm_mct_n_o, exp_mm_n);
         chk("if_n_o", if_mct_n_o, exp_if_n);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         compare_outputs();
      end
   end

   // Per-transaction observations for the hand-computed checks
   int          cyc;
   int          wr_cnt;
   int          other_ok;
   logic [31:0] alog [0:7];
   logic [31:0] wlog_a [0:3];
   logic [7:0]  wlog_d [0:3];

   task automatic run_data(input logic wr, input logic [1:0] cu, input logic [31:0] a,
                           input logic [31:0] d);
      mm_mct_e = 1'b1; mm_mct_wr = wr; mm_mct_cu = cu; mm_mct_a = a; mm_mct_n_i = d;
      cyc = 0; wr_cnt = 0; other_ok = 0;
      do begin
         @(negedge clk);
         if (cyc < 8) alog[cyc] = mem_a;
         if (mem_wr && wr_cnt < 4) begin
            wlog_a[wr_cnt] = mem_a;
            wlog_d[wr_cnt] = mem_dout;
         end
         if (mem_wr) wr_cnt++;
         if (if_mct_ok) other_ok++;
         cyc++;
      end while (!mm_mct_ok && cyc < 24);
      chk("mm_ok_timeout", 32'(mm_mct_ok), 32'd1);
      mm_mct_e = 1'b0;
   endtask

   task automatic run_fetch(input logic [31:0] a, input logic drop);
      if_mct_e = 1'b1; if_mct_a = a;
      cyc = 0; other_ok = 0;
      do begin
         @(negedge clk);
         if (cyc < 8) alog[cyc] = mem_a;
         if (mm_mct_ok) other_ok++;
         if (drop) if_mct_e = 1'b0;
         cyc++;
      end while (!if_mct_ok && cyc < 24);
      chk("if_ok_timeout", 32'(if_mct_ok), 32'd1);
      if_mct_e = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      preload(32'h100, 8'h11); preload(32'h101, 8'h22);
      preload(32'h102, 8'h33); preload(32'h103, 8'h44);
      preload(32'h200, 8'h01); preload(32'h201, 8'h02);
      preload(32'h202, 8'h77); preload(32'h203, 8'h88);
      preload(32'hFFFFFFFE, 8'hA1); preload(32'hFFFFFFFF, 8'hA2);
      preload(32'h0, 8'hA3); preload(32'h1, 8'hA4);
      preload(32'h2, 8'h55); preload(32'h3, 8'h66);

      repeat (3) @(negedge clk);
      chk("rst_mem_a", mem_a, 32'd0);
      chk("rst_mm_n_o", mm_mct_n_o, 32'd0);
      chk("rst_if_ok", 32'(if_mct_ok), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Asynchronous reset mid word load aborts it with no ok
      mm_mct_e = 1'b1; mm_mct_wr = 1'b0; mm_mct_cu = 2'd3; mm_mct_a = 32'h100;
      repeat (3) @(negedge clk);
      chk("abort_partial", mm_mct_n_o, 32'h00000011);
      #2 rst = 1'b1;
      #1;
      chk("abort_mem_a", mem_a, 32'd0);
      chk("abort_mm_n_o", mm_mct_n_o, 32'd0);
      chk("abort_mm_ok", 32'(mm_mct_ok), 32'd0);
      @(posedge clk);
      @(negedge clk);
      mm_mct_e = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      run_fetch(32'h0, 1'b0);
      chk("fetch0_val", if_mct_n_o, 32'h6655A4A3);
      chk("fetch0_lat", 32'(cyc), 32'd6);

      // Word load at 0x100
      @(negedge clk);
      run_data(1'b0, 2'd3, 32'h100, 32'h0);
      chk("wl_val", mm_mct_n_o, 32'h44332211);
      chk("wl_lat", 32'(cyc), 32'd6);
      chk("wl_a0", alog[0], 32'h100);
      chk("wl_a3", alog[3], 32'h103);
      chk("wl_nowr", 32'(wr_cnt), 32'd0);
      @(negedge clk);
      chk("wl_pulse", 32'(mm_mct_ok), 32'd0);

      // Half store then byte load of the upper stored byte
      run_data(1'b1, 2'd1, 32'h200, 32'hDEADBEEF);
      chk("hs_lat", 32'(cyc), 32'd3);
      chk("hs_wrcnt", 32'(wr_cnt), 32'd2);
      chk("hs_a0", wlog_a[0], 32'h200);
      chk("hs_d0", 32'(wlog_d[0]), 32'hEF);
      chk("hs_a1", wlog_a[1], 32'h201);
      chk("hs_d1", 32'(wlog_d[1]), 32'hBE);
      chk("hs_n_o", mm_mct_n_o, 32'd0);
      @(negedge clk);
      chk("hs_ram202", 32'(ram[32'h202]), 32'h77);
      run_data(1'b0, 2'd0, 32'h201, 32'h0);
      chk("bl_val", mm_mct_n_o, 32'h000000BE);
      chk("bl_lat", 32'(cyc), 32'd3);

      // Simultaneous requests: data first, fetch right after
      @(negedge clk);
      if_mct_e = 1'b1; if_mct_a = 32'h100;
      run_data(1'b0, 2'd1, 32'h100, 32'h0);
      chk("pri_no_if_ok", 32'(other_ok), 32'd0);
      chk("pri_mm_val", mm_mct_n_o, 32'h00002211);
      run_fetch(32'h100, 1'b0);
      chk("pri_if_lat", 32'(cyc), 32'd7);
      chk("pri_if_val", if_mct_n_o, 32'h44332211);
      @(negedge clk);
      chk("pri_if_pulse", 32'(if_mct_ok), 32'd0);

      // Address wrap past 0xFFFFFFFF
      run_data(1'b0, 2'd3, 32'hFFFFFFFE, 32'h0);
      chk("wrap_a0", alog[0], 32'hFFFFFFFE);
      chk("wrap_a1", alog[1], 32'hFFFFFFFF);
      chk("wrap_a2", alog[2], 32'h00000000);
      chk("wrap_a3", alog[3], 32'h00000001);
      chk("wrap_val", mm_mct_n_o, 32'hA4A3A2A1);

      // Fetch whose request drops right after accept
      @(negedge clk);
      run_fetch(32'h200, 1'b1);
      chk("drop_lat", 32'(cyc), 32'd6);
      other_ok = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (if_mct_ok) other_ok++;
      end
      chk("drop_extra_ok", 32'(other_ok), 32'd0);
      chk("drop_hold", if_mct_n_o, 32'h8877BEEF);

      // Back-to-back word store and load to the same address
      run_data(1'b1, 2'd3, 32'h300, 32'h12345678);
      chk("ws_lat", 32'(cyc), 32'd5);
      chk("ws_wrcnt", 32'(wr_cnt), 32'd4);
      run_data(1'b0, 2'd3, 32'h300, 32'h0);
      chk("b2b_val", mm_mct_n_o, 32'h12345678);
      chk("b2b_lat", 32'(cyc), 32'd7);

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
